// File: rtl/output_demux.sv
// 1:4 packet splitter: whole packets are steered by a one-hot tuser field to per-port fallthrough FIFOs.
// Latency 1 cycle input->output; input stalls only when the FIFO being written reaches 15 entries.

module demux_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int NF_THRESH = DEPTH - 1
) (
  input  logic             axis_clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] NF_CNT   = (AW+1)'(NF_THRESH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign do_wr       = wr_en & (count != FULL_CNT);
  assign do_rd       = rd_en & ~empty;
  assign dout        = mem[rd_ptr];
  assign empty       = (count == '0);
  assign nearly_full = (count >= NF_CNT);

  always_ff @(posedge axis_clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module output_demux #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES       = 4,
  parameter int C_NUM_QUEUES_WIDTH = 2,
  parameter int C_DST_OFFSET       = 24
) (
  input  logic                            axis_clk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_0,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                            m_axis_tlast_0,
  output logic                            m_axis_tvalid_0,
  input  logic                            m_axis_tready_0,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_1,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                            m_axis_tlast_1,
  output logic                            m_axis_tvalid_1,
  input  logic                            m_axis_tready_1,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_2,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                            m_axis_tlast_2,
  output logic                            m_axis_tvalid_2,
  input  logic                            m_axis_tready_2,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_3,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                            m_axis_tlast_3,
  output logic                            m_axis_tvalid_3,
  input  logic                            m_axis_tready_3,
  output logic [31:0]                     drop_count
);
  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]  tdata;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser;
    logic [KW-1:0]                 tkeep;
    logic                          tlast;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD_PKT, DROP_PKT} state_t;

  state_t                        state;
  logic [C_NUM_QUEUES_WIDTH-1:0] cur_queue, sel, wr_queue;
  logic [C_NUM_QUEUES-1:0]       dst_field, nearly_full, empty, wr_en, rd_en, m_rdy;
  logic                          no_dst, accept, fwd_beat;
  beat_t                         in_beat;
  beat_t                         out_beat [C_NUM_QUEUES];

  assign dst_field = s_axis_tuser[C_DST_OFFSET +: C_NUM_QUEUES];
  assign no_dst    = ~|dst_field;

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    sel = '0;
    for (int i = C_NUM_QUEUES - 1; i >= 0; i--) begin
      if (dst_field[i]) sel = C_NUM_QUEUES_WIDTH'(i);
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    wr_queue      = cur_queue;
    if (!reset) begin
      case (state)
        IDLE: begin
          wr_queue      = sel;
          s_axis_tready = no_dst | ~nearly_full[sel];
        end
        FWD_PKT:  s_axis_tready = ~nearly_full[cur_queue];
        DROP_PKT: s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end
  end

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign fwd_beat = accept & (((state == IDLE) & ~no_dst) | (state == FWD_PKT));
  assign wr_en    = fwd_beat ? (C_NUM_QUEUES'(1) << wr_queue) : '0;

  always_comb begin
    in_beat.tdata = s_axis_tdata;
    in_beat.tuser = s_axis_tuser;
    in_beat.tkeep = s_axis_tkeep;
    in_beat.tlast = s_axis_tlast;
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_queue  <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (no_dst) begin
              if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
              if (!s_axis_tlast) state <= DROP_PKT;
            end else begin
              cur_queue <= sel;
              if (!s_axis_tlast) state <= FWD_PKT;
            end
          end
        end
        FWD_PKT, DROP_PKT: begin
          if (accept && s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_rdy = {m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};

  for (genvar k = 0; k < C_NUM_QUEUES; k++) begin : g_q
    assign rd_en[k] = ~empty[k] & m_rdy[k];
    demux_fifo #(.WIDTH($bits(beat_t)), .DEPTH(16)) u_fifo (
      .axis_clk    (axis_clk),
      .reset       (reset),
      .wr_en       (wr_en[k]),
      .din         (in_beat),
      .rd_en       (rd_en[k]),
      .dout        (out_beat[k]),
      .empty       (empty[k]),
      .nearly_full (nearly_full[k])
    );
  end

  assign m_axis_tdata_0  = out_beat[0].tdata;
  assign m_axis_tkeep_0  = out_beat[0].tkeep;
  assign m_axis_tuser_0  = out_beat[0].tuser;
  assign m_axis_tlast_0  = out_beat[0].tlast;
  assign m_axis_tvalid_0 = ~empty[0];
  assign m_axis_tdata_1  = out_beat[1].tdata;
  assign m_axis_tkeep_1  = out_beat[1].tkeep;
  assign m_axis_tuser_1  = out_beat[1].tuser;
  assign m_axis_tlast_1  = out_beat[1].tlast;
  assign m_axis_tvalid_1 = ~empty[1];
  assign m_axis_tdata_2  = out_beat[2].tdata;
  assign m_axis_tkeep_2  = out_beat[2].tkeep;
  assign m_axis_tuser_2  = out_beat[2].tuser;
  assign m_axis_tlast_2  = out_beat[2].tlast;
  assign m_axis_tvalid_2 = ~empty[2];
  assign m_axis_tdata_3  = out_beat[3].tdata;
  assign m_axis_tkeep_3  = out_beat[3].tkeep;
  assign m_axis_tuser_3  = out_beat[3].tuser;
  assign m_axis_tlast_3  = out_beat[3].tlast;
  assign m_axis_tvalid_3 = ~empty[3];
endmodule
